dmem_responder: RTL and testbench

Data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready request channel and a valid/ready response channel. It holds a word-addressed RAM, inserts a programmable number of wait states per access, applies byte strobes on stores, and flags misaligned or out-of-range accesses. It is the memory-side counterpart of the pipeline's data-access initiator and supports multi-cycle memory and stall testing.

---
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder_if : valid/ready request + response channel bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder : word RAM with programmable wait states, strobes, faults. Rev 1.0
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);
  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             do_access;
  logic             acc_write;
  logic             acc_err;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_wstrb;
  logic [IDX_W-1:0] acc_idx;

  // A zero-latency access happens on the accept edge, so it must use the live request.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wstrb = bus.req_wstrb;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
    acc_idx = acc_addr[IDX_W+1:2];
    acc_err = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:IDX_W+2]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          if (LATENCY == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          cnt_d     = 4'd0;
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is deliberately not reset; rst_n only blocks a same-edge zero-latency store.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_responder : randomized bench with a word-array reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  localparam int DEPTH = 256;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // ref_mem[0] mirrors the LATENCY=0 instance, ref_mem[1] the LATENCY=2 instance
  logic [31:0] ref_mem [2][DEPTH];

  dmem_responder_if if2();
  dmem_responder_if if0();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd, output logic e);
    int unsigned widx;
    widx = a / 4;
    e    = (a % 4 != 0) || (widx >= DEPTH);
    rd   = 32'd0;
    if (!e) begin
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) ref_mem[m][widx][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        rd = ref_mem[m][widx];
      end
    end
  endfunction

  function automatic logic [31:0] rand_addr(input int nwords);
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(19, 0);
    a = 32'($urandom_range(nwords - 1, 0)) << 2;
    if (k < 3) a[1:0] = 2'($urandom_range(3, 1));
    else if (k < 6) a = 32'($urandom_range(32'h3FFF_FFFF, DEPTH)) << 2;
    return a;
  endfunction

  // One transaction on the LATENCY=2 instance; stall = cycles rsp_ready is held low after rsp_valid.
  task automatic xact2(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int stall, output logic [31:0] rd, output logic e, output int lat,
                       output bit stable, output bit rdy_after, output bit tmo,
                       output logic [31:0] exp_rd, output logic exp_e);
    int n;
    tmo = 0; stable = 1; lat = 0; rd = '0; e = 1'b0; rdy_after = 0;
    exp_rd = '0; exp_e = 1'b0;
    @(negedge clk);
    if2.req_valid = 1'b1; if2.req_write = w; if2.req_addr = a;
    if2.req_wdata = d;    if2.req_wstrb = s;
    n = 0;
    while (!if2.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!if2.req_ready) begin tmo = 1; if2.req_valid = 1'b0; return; end
    model(1, w, a, d, s, exp_rd, exp_e);
    @(negedge clk);
    if2.req_valid = 1'b0; if2.req_write = 1'($urandom);
    if2.req_addr  = $urandom; if2.req_wdata = $urandom; if2.req_wstrb = 4'($urandom);
    lat = 1;
    while (!if2.rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!if2.rsp_valid) begin tmo = 1; return; end
    rd = if2.rsp_rdata; e = if2.rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!if2.rsp_valid || if2.req_ready || if2.rsp_rdata !== rd || if2.rsp_err !== e) stable = 0;
    end
    if2.rsp_ready = 1'b1;
    @(negedge clk);
    if2.rsp_ready = 1'b0;
    rdy_after = (if2.req_ready === 1'b1) && (if2.rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if2.req_valid = 1'b1; if2.req_write = 1'b1; if2.req_addr = 32'h0;
    if2.req_wdata = $urandom; if2.req_wstrb = 4'hF; if2.rsp_ready = 1'b0;
    if0.req_valid = 1'b1; if0.req_write = 1'b1; if0.req_addr = 32'h0;
    if0.req_wdata = $urandom; if0.req_wstrb = 4'hF; if0.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      total++;
      if ({if2.req_ready, if2.rsp_valid, if2.rsp_err} !== 3'b100 || if2.rsp_rdata !== 32'd0) begin
        bad++;
        $display("FAIL reset_lat2 pass%0d ready/valid/err=%b rdata=%h, required 100 rdata=00000000",
                 pass, {if2.req_ready, if2.rsp_valid, if2.rsp_err}, if2.rsp_rdata);
      end
      total++;
      if ({if0.req_ready, if0.rsp_valid, if0.rsp_err} !== 3'b100 || if0.rsp_rdata !== 32'd0) begin
        bad++;
        $display("FAIL reset_lat0 pass%0d ready/valid/err=%b rdata=%h, required 100 rdata=00000000",
                 pass, {if0.req_ready, if0.rsp_valid, if0.rsp_err}, if0.rsp_rdata);
      end
      if2.req_valid = 1'b0; if0.req_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_preload();
    logic [31:0] rd, erd; logic e, ee; int lat; bit st, ra, tmo;
    for (int i = 0; i < DEPTH; i++) begin
      xact2(1'b1, 32'(i) << 2, $urandom, 4'hF, 0, rd, e, lat, st, ra, tmo, erd, ee);
      total++;
      if (tmo || lat != 3 || e !== 1'b0 || rd !== 32'd0 || !ra) begin
        bad++;
        $display("FAIL preload word %0d tmo=%0d lat=%0d err=%b rdata=%h ready_after=%0d, required lat=3 err=0 rdata=0 ready_after=1",
                 i, tmo, lat, e, rd, ra);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic e, ee; int lat; bit st, ra, tmo;
    xact2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e, lat, st, ra, tmo, erd, ee);
    total++;
    if (tmo || lat != 3 || e !== 1'b0 || rd !== 32'd0) begin
      bad++;
      $display("FAIL store_0x10 tmo=%0d lat=%0d err=%b rdata=%h, required lat=3 err=0 rdata=0", tmo, lat, e, rd);
    end
    xact2(1'b0, 32'h10, $urandom, 4'($urandom), 0, rd, e, lat, st, ra, tmo, erd, ee);
    total++;
    if (tmo || lat != 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL load_0x10 tmo=%0d lat=%0d err=%b rdata=%h, required lat=3 err=0 rdata=deadbeef", tmo, lat, e, rd);
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd, erd; logic e, ee; int lat; bit st, ra, tmo;
    xact2(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, e, lat, st, ra, tmo, erd, ee);
    xact2(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, e, lat, st, ra, tmo, erd, ee);
    xact2(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat, st, ra, tmo, erd, ee);
    total++;
    if (tmo || e !== 1'b0 || rd !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL partial_store tmo=%0d err=%b rdata=%h, required err=0 rdata=11bb33dd", tmo, e, rd);
    end
    xact2(1'b1, 32'h20, $urandom, 4'b0000, 0, rd, e, lat, st, ra, tmo, erd, ee);
    xact2(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat, st, ra, tmo, erd, ee);
    total++;
    if (tmo || e !== 1'b0 || rd !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL null_strobe tmo=%0d err=%b rdata=%h, required err=0 rdata=11bb33dd", tmo, e, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic e, ee; int lat; bit st, ra, tmo;
    xact2(1'b0, 32'h22, 32'h0, 4'h0, 0, rd, e, lat, st, ra, tmo, erd, ee);
    total++;
    if (tmo || e !== 1'b1 || rd !== 32'd0) begin
      bad++;
      $display("FAIL misaligned_load tmo=%0d err=%b rdata=%h, required err=1 rdata=0", tmo, e, rd);
    end
    xact2(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, rd, e, lat, st, ra, tmo, erd, ee);
    total++;
    if (tmo || e !== 1'b1 || rd !== 32'd0) begin
      bad++;
      $display("FAIL range_store tmo=%0d err=%b rdata=%h, required err=1 rdata=0", tmo, e, rd);
    end
    xact2(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, e, lat, st, ra, tmo, erd, ee);
    total++;
    if (tmo || e !== 1'b0 || rd !== ref_mem[1][0]) begin
      bad++;
      $display("FAIL word0_untouched tmo=%0d err=%b rdata=%h, required err=0 rdata=%h", tmo, e, rd, ref_mem[1][0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd; logic e, ee; int lat; bit st, ra, tmo;
    for (int i = 0; i < 3; i++) begin
      xact2(i == 1, (i == 2) ? 32'h41 : 32'($urandom_range(DEPTH - 1, 0)) << 2, $urandom, 4'($urandom),
            5, rd, e, lat, st, ra, tmo, erd, ee);
      total++;
      if (tmo || !st || !ra || rd !== erd || e !== ee) begin
        bad++;
        $display("FAIL backpressure%0d tmo=%0d stable=%0d ready_after=%0d rdata=%h err=%b, required stable=1 ready_after=1 rdata=%h err=%b",
                 i, tmo, st, ra, rd, e, erd, ee);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, erd; logic e, ee; int lat; bit st, ra, tmo;
    xact2(1'b1, 32'h30, 32'h0, 4'hF, 0, rd, e, lat, st, ra, tmo, erd, ee);
    xact2(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat, st, ra, tmo, erd, ee);
    @(negedge clk);
    if2.req_valid = 1'b1; if2.req_write = 1'b1; if2.req_addr = 32'h30;
    if2.req_wdata = 32'h55555555; if2.req_wstrb = 4'hF;
    @(posedge clk);
    #1 if2.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (if2.req_ready !== 1'b0 || if2.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL in_wait ready=%b valid=%b, required ready=0 valid=0", if2.req_ready, if2.rsp_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({if2.req_ready, if2.rsp_valid, if2.rsp_err} !== 3'b100 || if2.rsp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL async_reset ready/valid/err=%b rdata=%h, required 100 rdata=00000000",
               {if2.req_ready, if2.rsp_valid, if2.rsp_err}, if2.rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    xact2(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, e, lat, st, ra, tmo, erd, ee);
    total++;
    if (tmo || e !== 1'b0 || rd !== 32'd0) begin
      bad++;
      $display("FAIL discarded_store tmo=%0d err=%b rdata=%h, required err=0 rdata=0", tmo, e, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd; logic e, ee; int lat; bit st, ra, tmo;
    for (int i = 0; i < 150; i++) begin
      xact2(1'($urandom), rand_addr(DEPTH), $urandom, 4'($urandom), $urandom_range(2, 0),
            rd, e, lat, st, ra, tmo, erd, ee);
      total++;
      if (tmo || lat != 3 || !st || !ra || rd !== erd || e !== ee) begin
        bad++;
        $display("FAIL random%0d tmo=%0d lat=%0d stable=%0d ready_after=%0d rdata=%h err=%b, required lat=3 rdata=%h err=%b",
                 i, tmo, lat, st, ra, rd, e, erd, ee);
      end
    end
  endtask

  // LATENCY=0 stream with rsp_ready tied high: first 16 requests seed words 0..15.
  task automatic test_back_to_back();
    logic [31:0] q_rd[$]; logic q_e[$]; int q_cyc[$];
    logic [31:0] erd, ca, cd; logic ee; logic [3:0] cs; bit cw;
    int cyc, n_acc, n_rsp, last_acc; bit acc_now;
    localparam int N = 60;
    cyc = 0; n_acc = 0; n_rsp = 0; last_acc = -1;
    if0.rsp_ready = 1'b1;
    cw = 1'b1; ca = 32'h0; cd = $urandom; cs = 4'hF;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_write = cw; if0.req_addr = ca; if0.req_wdata = cd; if0.req_wstrb = cs;
    while (n_rsp < N && cyc < 400) begin
      acc_now = 0;
      if (if0.rsp_valid) begin
        total++;
        if (q_rd.size() == 0 || if0.rsp_rdata !== q_rd[0] || if0.rsp_err !== q_e[0] || cyc != q_cyc[0] + 1) begin
          bad++;
          $display("FAIL b2b_rsp%0d cycle=%0d rdata=%h err=%b, required cycle=%0d rdata=%h err=%b", n_rsp, cyc,
                   if0.rsp_rdata, if0.rsp_err, (q_cyc.size() != 0) ? q_cyc[0] + 1 : -1,
                   (q_rd.size() != 0) ? q_rd[0] : 32'hx, (q_e.size() != 0) ? q_e[0] : 1'bx);
        end
        if (q_rd.size() != 0) begin void'(q_rd.pop_front()); void'(q_e.pop_front()); void'(q_cyc.pop_front()); end
        n_rsp++;
      end
      if (if0.req_ready && n_acc < N) begin
        model(0, cw, ca, cd, cs, erd, ee);
        q_rd.push_back(erd); q_e.push_back(ee); q_cyc.push_back(cyc);
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != 2) begin
            bad++;
            $display("FAIL b2b_spacing acc%0d spacing=%0d, required 2", n_acc, cyc - last_acc);
          end
        end
        last_acc = cyc; n_acc++; acc_now = 1;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (n_acc < 16) begin
          cw = 1'b1; ca = 32'(n_acc) << 2; cd = $urandom; cs = 4'hF;
        end else begin
          cw = 1'($urandom); ca = rand_addr(16); cd = $urandom; cs = 4'($urandom);
        end
        if0.req_valid = (n_acc < N); if0.req_write = cw; if0.req_addr = ca;
        if0.req_wdata = cd; if0.req_wstrb = cs;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (n_rsp < N) begin
      bad++;
      $display("FAIL b2b_timeout responses=%0d, required %0d", n_rsp, N);
    end
    if0.req_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_preload();
    test_store_load();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
